// File: rtl/load_pkg.sv
// ============================================================================
// load_pkg: size encodings, FSM state type and defaults for load_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package load_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Size 2'b11 behaves as a word, so any size with bit 1 set needs word alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) begin
      mis = lo[0];
    end else if (size[1]) begin
      mis = (lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
// load_extract: little-endian byte/half/word lane select with zero/sign extend.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_extract
  import load_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = data_i[7:0];
      2'd1:    byte_v = data_i[15:8];
      2'd2:    byte_v = data_i[23:16];
      default: byte_v = data_i[31:24];
    endcase
  end

  // Halfword lane comes from Addr[1] only; Addr[0] is ignored here.
  assign half_v = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    result_o = data_i;
    case (size_i)
      SZ_BYTE: result_o = {{24{signed_i & byte_v[7]}}, byte_v};
      SZ_HALF: result_o = {{16{signed_i & half_v[15]}}, half_v};
      default: result_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_unit.sv
// ============================================================================
// load_unit: multi-cycle load controller (word read over req/ack, extract, extend).
// Option: define LOAD_MISALIGN_CHECK_EN to abort misaligned half/word loads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_unit
  import load_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Addr,
  input  logic [1:0]  Size,
  input  logic        Signed,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Dout,
  output logic        Err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [1:0]    lo_q, lo_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [31:0]   dout_q, dout_d;
  logic          err_q, err_d;

  logic [31:0]   ext_data;
  logic          start_misaligned;

  load_extract u_extract (
    .data_i    (mem_rdata),
    .addr_lo_i (lo_q),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .result_o  (ext_data)
  );

`ifdef LOAD_MISALIGN_CHECK_EN
  assign start_misaligned = is_misaligned(Size, Addr[1:0]);
`else
  assign start_misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    lo_d       = lo_q;
    size_d     = size_q;
    signed_d   = signed_q;
    dout_d     = dout_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          mem_addr_d = {Addr[31:2], 2'b00};
          lo_d       = Addr[1:0];
          size_d     = Size;
          signed_d   = Signed;
          cnt_d      = '0;
          if (start_misaligned) begin
            dout_d  = 32'h0;
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        // Ack is checked first so it wins over a coincident timeout.
        if (mem_ack) begin
          dout_d  = ext_data;
          err_d   = 1'b0;
          state_d = FIN;
        end else if (cnt_q == CNT_LAST) begin
          dout_d  = 32'h0;
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_addr_q <= 32'h0;
      lo_q       <= 2'b00;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      dout_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      lo_q       <= lo_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == FIN);
  assign mem_req  = (state_q == REQ);
  assign Dout     = dout_q;
  assign Err      = err_q;
  assign mem_addr = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_load_unit.sv
// ============================================================================
// tb_load_unit: vector table, corner sequences and random loads vs. a model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_unit;

  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        Reset, Start, Signed, mem_ack;
  logic [31:0] Addr, mem_rdata;
  logic [1:0]  Size;
  logic        Busy, Done, Err, mem_req;
  logic [31:0] Dout, mem_addr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  load_unit #(.TIMEOUT(TMO)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Start     (Start),
    .Addr      (Addr),
    .Size      (Size),
    .Signed    (Signed),
    .Busy      (Busy),
    .Done      (Done),
    .Dout      (Dout),
    .Err       (Err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] exp_dout;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: result follows from the byte address, size and ack delay alone.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                                input logic [31:0] rd, input int dly,
                                output logic [31:0] dout, output logic err, output int done_t);
    logic [31:0] v;
    logic        mis;
    mis = 1'b0;
`ifdef LOAD_MISALIGN_CHECK_EN
    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && (a % 4) != 0);
`endif
    if (mis) begin
      dout = 0; err = 1'b1; done_t = 1;
    end else if (dly < 0 || dly >= TMO) begin
      dout = 0; err = 1'b1; done_t = TMO + 1;
    end else begin
      err = 1'b0; done_t = dly + 2;
      if (sz == 2'd0) begin
        v = (rd >> (8 * (a % 4))) & 32'hFF;
        if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
        v = rd;
      end
      dout = v;
    end
  endfunction

  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                          input logic [31:0] rd, input int dly,
                          output int done_t, output logic [31:0] dout, output logic err,
                          output int req_n, output logic [31:0] maddr,
                          output logic done_after, output logic busy_after);
    done_t = 0; req_n = 0; maddr = 0; dout = 0; err = 0; done_after = 1; busy_after = 1;
    @(negedge CLK);
    Start = 1; Addr = a; Size = sz; Signed = sg;
    @(negedge CLK);
    Start = 0; Addr = $urandom(); Size = 2'($urandom()); Signed = 1'($urandom());
    for (int t = 1; t <= TMO + 10; t++) begin
      if (Done) begin
        done_t = t; dout = Dout; err = Err; mem_ack = 0;
        @(negedge CLK);
        done_after = Done; busy_after = Busy;
        break;
      end
      if (mem_req) begin
        maddr = mem_addr;
        req_n++;
        mem_ack   = (dly >= 0 && req_n - 1 == dly);
        mem_rdata = mem_ack ? rd : $urandom();
      end else begin
        mem_ack = 0;
      end
      @(negedge CLK);
    end
    mem_ack = 0;
  endtask

  task automatic load_and_check(input string tag, input logic [31:0] a, input logic [1:0] sz,
                                input logic sg, input logic [31:0] rd, input int dly,
                                input logic [31:0] e_dout, input logic e_err, input int e_done);
    int done_t, req_n;
    logic [31:0] dout, maddr;
    logic err, d_after, b_after;
    run_load(a, sz, sg, rd, dly, done_t, dout, err, req_n, maddr, d_after, b_after);
    chk({tag, " done_cycle"}, 32'(done_t), 32'(e_done));
    chk({tag, " dout"}, dout, e_dout);
    chk({tag, " err"}, 32'(err), 32'(e_err));
    chk({tag, " req_cycles"}, 32'(req_n), 32'(e_done - 1));
    if (e_done > 1) chk({tag, " mem_addr"}, maddr, a & 32'hFFFF_FFFC);
    chk({tag, " done_one_cycle"}, 32'(d_after), 32'd0);
    chk({tag, " idle_after"}, 32'(b_after), 32'd0);
  endtask

  initial begin
    logic [31:0] e_dout, a, rd;
    logic        e_err;
    int          e_done, dly;
    logic [1:0]  sz;
    logic        sg;
    bit          seen;

    Reset = 1; Start = 0; Addr = 0; Size = 0; Signed = 0; mem_ack = 0; mem_rdata = 0;

    tbl[0]  = '{32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 2};
    tbl[1]  = '{32'h103, 2'd0, 1'b1, 32'h80FF_1234, 0, 32'hFFFF_FF80, 1'b0, 2};
    tbl[2]  = '{32'h103, 2'd0, 1'b0, 32'h80FF_1234, 0, 32'h0000_0080, 1'b0, 2};
    tbl[3]  = '{32'h102, 2'd1, 1'b1, 32'h8001_7FFF, 3, 32'hFFFF_8001, 1'b0, 5};
    tbl[4]  = '{32'h100, 2'd1, 1'b1, 32'h8001_7FFF, 1, 32'h0000_7FFF, 1'b0, 3};
    tbl[5]  = '{32'h101, 2'd0, 1'b1, 32'h80FF_1234, 2, 32'h0000_0012, 1'b0, 4};
    tbl[6]  = '{32'h102, 2'd0, 1'b1, 32'h80FF_1234, 0, 32'hFFFF_FFFF, 1'b0, 2};
    tbl[7]  = '{32'h200, 2'd2, 1'b0, 32'h1111_1111, -1, 32'h0, 1'b1, TMO + 1};
    tbl[8]  = '{32'h204, 2'd3, 1'b0, 32'h1234_5678, TMO - 1, 32'h1234_5678, 1'b0, TMO + 1};
`ifdef LOAD_MISALIGN_CHECK_EN
    tbl[9]  = '{32'h101, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 32'h0, 1'b1, 1};
    tbl[10] = '{32'h103, 2'd1, 1'b0, 32'h8001_7FFF, 0, 32'h0, 1'b1, 1};
`else
    tbl[9]  = '{32'h101, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 2};
    tbl[10] = '{32'h103, 2'd1, 1'b0, 32'h8001_7FFF, 0, 32'h0000_8001, 1'b0, 2};
`endif

    repeat (3) @(negedge CLK);
    chk("reset busy", 32'(Busy), 0);
    chk("reset done", 32'(Done), 0);
    chk("reset err", 32'(Err), 0);
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset dout", Dout, 0);
    chk("reset mem_addr", mem_addr, 0);
    Reset = 0;

    for (int i = 0; i < 11; i++) begin
      load_and_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].size, tbl[i].sgn,
                     tbl[i].rdata, tbl[i].dly, tbl[i].exp_dout, tbl[i].exp_err, tbl[i].exp_done);
    end

    // Timeout followed by a stray ack in IDLE: result must not change.
    load_and_check("tmo", 32'h300, 2'd2, 1'b0, 32'h0, -1, 32'h0, 1'b1, TMO + 1);
    mem_ack = 1; mem_rdata = 32'hA5A5_A5A5;
    @(negedge CLK);
    mem_ack = 0;
    chk("late_ack busy", 32'(Busy), 0);
    chk("late_ack done", 32'(Done), 0);
    @(negedge CLK);
    chk("late_ack dout", Dout, 0);
    chk("late_ack err", 32'(Err), 1);
    chk("late_ack mem_req", 32'(mem_req), 0);

    // Start during REQ and during FIN is ignored.
    Start = 1; Addr = 32'h100; Size = 2'd2; Signed = 0;
    @(negedge CLK);
    Addr = 32'h500;
    @(negedge CLK);
    Start = 0;
    chk("busy_start mem_addr", mem_addr, 32'h100);
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    @(negedge CLK);
    mem_ack = 0;
    chk("busy_start done", 32'(Done), 1);
    chk("busy_start dout", Dout, 32'h0BAD_F00D);
    Start = 1; Addr = 32'h600;
    @(negedge CLK);
    Start = 0;
    chk("fin_start busy", 32'(Busy), 0);
    @(negedge CLK);
    chk("fin_start still_idle", 32'(Busy), 0);

    // Reset in the second REQ cycle, ack the cycle after.
    Reset = 1;
    @(negedge CLK);
    Reset = 0;
    Start = 1; Addr = 32'h400; Size = 2'd2;
    @(negedge CLK);
    Start = 0;
    @(negedge CLK);
    chk("rst_mid req2", 32'(mem_req), 1);
    Reset = 1;
    @(negedge CLK);
    Reset = 0;
    chk("rst_mid mem_req", 32'(mem_req), 0);
    chk("rst_mid busy", 32'(Busy), 0);
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    @(negedge CLK);
    mem_ack = 0;
    seen = 0;
    for (int t = 0; t < 4; t++) begin
      if (Done || Busy || mem_req) seen = 1;
      @(negedge CLK);
    end
    chk("rst_mid no_activity", 32'(seen), 0);
    chk("rst_mid dout", Dout, 0);

    // Random loads against the model.
    for (int i = 0; i < 40; i++) begin
      a   = $urandom();
      sz  = 2'($urandom_range(0, 3));
      sg  = 1'($urandom());
      rd  = $urandom();
      dly = int'($urandom_range(0, TMO + 1));
      if (dly >= TMO) dly = -1;
      model(a, sz, sg, rd, dly, e_dout, e_err, e_done);
      load_and_check($sformatf("rnd%0d", i), a, sz, sg, rd, dly, e_dout, e_err, e_done);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
